// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte signals of the UART receiver
interface uart_rx_if;
  logic       rx_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err_out;
  logic       busy_out;

  // Line driver / byte consumer side.
  modport master (
    output rx_in,
    input  data_out,
    input  valid_out,
    input  frame_err_out,
    input  busy_out
  );

  // Receiver side.
  modport slave (
    input  rx_in,
    output data_out,
    output valid_out,
    output frame_err_out,
    output busy_out
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and one-cycle byte strobe
module uart_rx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic     clk_in,
  input  logic     rst_in,
  uart_rx_if.slave bus
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV);

  // Counter starts at 0 on the cycle after a transition, so the sample
  // lands on count N-1 to hit exactly N cycles after the transition cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  logic             rx_meta;
  logic             rx_s;
  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic [7:0]       data_q;
  logic [7:0]       data_d;
  logic             valid_q;
  logic             valid_d;
  logic             ferr_q;
  logic             ferr_d;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Saturating increment keeps the counter within 0..BAUD_DIV-1.
  assign cnt_inc = (cnt < CNT_LAST) ? cnt + CNT_W'(1) : cnt;

  // Next-state, counter, shift register and strobe decode.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d   = ST_START;
          bit_idx_d = 3'd0;
        end
      end
      ST_START: begin
        if (cnt == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // A line already back high at mid start bit was a glitch.
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_HIGH: begin
        // Hold off re-arming while the line sits in break / stuck low.
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered strobe outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.data_out      = data_q;
  assign bus.valid_out     = valid_q;
  assign bus.frame_err_out = ferr_q;
  assign bus.busy_out      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a timing model
module tb_uart_rx;

  localparam int B = 10;
  localparam int H = 5;

  logic clk_in;
  logic rst_in;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_HZ(1_000_000),
    .BAUD  (100_000)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: synchroniser as a 2-deep delay line, frame decoding from absolute
  // sample times measured from the first low cycle seen while idle.
  typedef enum {M_IDLE, M_ACTIVE, M_WAIT} mode_t;
  mode_t      m_mode  = M_IDLE;
  logic       s1 = 1'b1;
  logic       s2 = 1'b1;
  int         cyc = 0;
  int         t0 = 0;
  logic [7:0] bits = 8'h00;
  logic [7:0] e_data = 8'h00;
  logic       e_valid = 1'b0;
  logic       e_ferr = 1'b0;
  bit         model_on = 1'b0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         vcyc_q[$];
  int         ferr_cnt = 0;
  int         busy_cnt = 0;

  always @(negedge clk_in) begin
    logic rxs;
    int   rel;
    if (model_on) begin
      chk("busy",      {31'd0, bus.busy_out},      {31'd0, m_mode != M_IDLE});
      chk("valid",     {31'd0, bus.valid_out},     {31'd0, e_valid});
      chk("frame_err", {31'd0, bus.frame_err_out}, {31'd0, e_ferr});
      chk("data",      {24'd0, bus.data_out},      {24'd0, e_data});
      if (bus.valid_out === 1'b1) begin
        rx_q.push_back(bus.data_out);
        vcyc_q.push_back(cyc);
      end
      if (bus.frame_err_out === 1'b1) ferr_cnt++;
      if (bus.busy_out === 1'b1) busy_cnt++;
    end
    if (rst_in) begin
      m_mode   = M_IDLE;
      s1       = 1'b1;
      s2       = 1'b1;
      e_valid  = 1'b0;
      e_ferr   = 1'b0;
      e_data   = 8'h00;
      model_on = 1'b1;
    end else begin
      rxs     = s2;
      e_valid = 1'b0;
      e_ferr  = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (!rxs) begin
            t0     = cyc;
            m_mode = M_ACTIVE;
          end
        end
        M_ACTIVE: begin
          rel = cyc - t0;
          if (rel == H) begin
            if (rxs) m_mode = M_IDLE;
          end else if (rel > H && rel < H + 9 * B && (rel - H) % B == 0) begin
            bits[(rel - H) / B - 1] = rxs;
          end else if (rel == H + 9 * B) begin
            if (rxs) begin
              e_valid = 1'b1;
              e_data  = bits;
              m_mode  = M_IDLE;
            end else begin
              e_ferr = 1'b1;
              m_mode = M_WAIT;
            end
          end
        end
        default: begin
          if (rxs) m_mode = M_IDLE;
        end
      endcase
      s2 = s1;
      s1 = bus.rx_in;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic line(input logic v, input int n);
    bus.rx_in = v;
    repeat (n) tick();
  endtask

  // Bit periods jittered in +d/-d pairs so the edge drift stays within 0..jit.
  // stop_low > 0 holds the stop bit low for that many cycles.
  task automatic send_byte(input logic [7:0] b, input int jit, input int stop_low);
    int   d;
    int   dur;
    logic v;
    d = 0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        d   = (jit > 0) ? int'($urandom_range(jit, 0)) : 0;
        dur = B + d;
      end else begin
        dur = B - d;
      end
      if (i == 0) v = 1'b0;
      else if (i <= 8) v = b[i-1];
      else v = 1'b1;
      if (i == 9 && stop_low > 0) line(1'b0, stop_low);
      else line(v, dur);
    end
  endtask

  task automatic clear_logs();
    rx_q.delete();
    exp_q.delete();
    vcyc_q.delete();
    ferr_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic check_bytes(input string name);
    chk({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({name, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    int n_bad;
    int gap;
    logic [7:0] b;
    bus.rx_in = 1'b1;
    rst_in    = 1'b1;
    repeat (3) tick();
    rst_in = 1'b0;
    repeat (5) tick();
    chk("reset_data",  {24'd0, bus.data_out}, 32'h0);
    chk("reset_valid", {31'd0, bus.valid_out}, 32'h0);
    chk("reset_ferr",  {31'd0, bus.frame_err_out}, 32'h0);
    chk("reset_busy",  {31'd0, bus.busy_out}, 32'h0);

    // Single byte.
    clear_logs();
    send_byte(8'h55, 0, 0);
    line(1'b1, 20);
    exp_q.push_back(8'h55);
    check_bytes("t1");
    chk("t1_ferr", ferr_cnt, 0);
    chk("t1_data", {24'd0, bus.data_out}, 32'h55);
    chk("t1_model", {24'd0, e_data}, 32'h55);
    chk("t1_busy", {31'd0, bus.busy_out}, 32'h0);

    // Back-to-back frames with no idle gap.
    clear_logs();
    send_byte(8'h00, 0, 0);
    send_byte(8'hFF, 0, 0);
    send_byte(8'hA3, 0, 0);
    line(1'b1, 20);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hA3);
    check_bytes("t2");
    if (vcyc_q.size() == 3) begin
      chk("t2_spacing0", vcyc_q[1] - vcyc_q[0], 100);
      chk("t2_spacing1", vcyc_q[2] - vcyc_q[1], 100);
    end

    // Short low glitch on an idle line.
    clear_logs();
    line(1'b0, 3);
    line(1'b1, 20);
    check_bytes("t3");
    chk("t3_ferr", ferr_cnt, 0);
    chk("t3_busy_cycles", busy_cnt, 5);

    // Stop bit held low: frame error, data held, no re-arm while low.
    clear_logs();
    send_byte(8'h3C, 0, 30);
    line(1'b1, 20);
    check_bytes("t4");
    chk("t4_ferr", ferr_cnt, 1);
    chk("t4_data_held", {24'd0, bus.data_out}, 32'hA3);

    // Reset in the middle of a frame, then a clean frame.
    clear_logs();
    line(1'b0, B);
    line(1'b1, B);
    line(1'b0, B);
    line(1'b0, B);
    line(1'b0, B);
    line(1'b0, H);
    rst_in    = 1'b1;
    bus.rx_in = 1'b1;
    repeat (3) tick();
    chk("t5_rst_data", {24'd0, bus.data_out}, 32'h0);
    chk("t5_rst_busy", {31'd0, bus.busy_out}, 32'h0);
    rst_in = 1'b0;
    line(1'b1, 20);
    send_byte(8'h7E, 0, 0);
    line(1'b1, 20);
    exp_q.push_back(8'h7E);
    check_bytes("t5");
    chk("t5_ferr", ferr_cnt, 0);
    chk("t5_data", {24'd0, bus.data_out}, 32'h7E);

    // Jittered bit periods.
    clear_logs();
    send_byte(8'hC5, 2, 0);
    line(1'b1, 20);
    exp_q.push_back(8'hC5);
    check_bytes("t6");

    // Random frames, gaps, jitter, bad stops and glitches.
    clear_logs();
    n_bad = 0;
    for (int f = 0; f < 40; f++) begin
      b   = 8'($urandom);
      gap = int'($urandom_range(15, 0));
      if ($urandom_range(7, 0) == 0) begin
        line(1'b0, int'($urandom_range(3, 1)));
        line(1'b1, 8);
      end
      if ($urandom_range(9, 0) == 0) begin
        send_byte(b, int'($urandom_range(2, 0)), int'($urandom_range(25, 10)));
        n_bad++;
        gap = gap + 2;
      end else begin
        send_byte(b, int'($urandom_range(2, 0)), 0);
        exp_q.push_back(b);
      end
      if (gap > 0) line(1'b1, gap);
    end
    line(1'b1, 30);
    check_bytes("t7");
    chk("t7_ferr", ferr_cnt, n_bad);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
